ram_read_streamer: RTL

Single-clock read-side engine that sits directly downstream of the 64x8 dual-port RAM's read port. It accepts a burst command (start address, length), drives the RAM read address, and absorbs the RAM's two-cycle registered-read latency. It presents the returned bytes as a valid/ready stream with a last-beat flag. A small credit-controlled output FIFO lets the consumer stall at any time without losing in-flight data.

---
 rtl/ram_read_streamer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ram_read_streamer.sv
// Burst read engine for the 64x8 RAM read port: issues addresses, tracks the
// two-cycle read latency with tags, and streams returned bytes through a FIFO.
module ram_read_streamer #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              done_q;
  logic              s1_q, s1_last_q;
  logic              s2_q, s2_last_q;

  logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
  logic              fl_q [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW:0]       credit;
  logic              issue, push, pop, last_hs;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Reads in flight count against FIFO space so returns always fit.
  assign credit  = {1'b0, cnt_q} + (CW+1)'(s1_q) + (CW+1)'(s2_q);
  assign issue   = (state_q == ISSUE) && (credit < (CW+1)'(FIFO_DEPTH));
  assign push    = s2_q;
  assign m_valid = (cnt_q != '0);
  assign pop     = m_valid && m_ready;
  assign last_hs = pop && m_last;
  assign m_data  = fd_q[rp_q];
  assign m_last  = fl_q[rp_q];

  assign cmd_ready     = (state_q == IDLE) && !rst;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign ram_read_addr = addr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      s1_q      <= 1'b0;
      s1_last_q <= 1'b0;
      s2_q      <= 1'b0;
      s2_last_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      s1_q      <= issue;
      s1_last_q <= issue && (rem_q == (ADDR_W+1)'(1));
      s2_q      <= s1_q;
      s2_last_q <= s1_last_q;
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= cmd_addr;
              rem_q   <= cmd_len;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - (ADDR_W+1)'(1);
            if (rem_q == (ADDR_W+1)'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_hs) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fd_q[i] <= '0;
        fl_q[i] <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        fd_q[wp_q] <= ram_q;
        fl_q[wp_q] <= s2_last_q;
        wp_q       <= ptr_inc(wp_q);
      end
      if (pop) rp_q <= ptr_inc(rp_q);
    end
  end

  always @(posedge clk) begin
    if (!rst) assert (!(push && cnt_q == CW'(FIFO_DEPTH)));
  end

endmodule
